// File: rtl/wb_arbiter_rr.sv
// Round-robin Wishbone arbiter: holds the bus for a whole cyc transaction, then rotates priority.
// Define WB_ARB_TIMEOUT_EN to build the stalled-strobe watchdog that raises timeout_err.
module wb_arbiter_rr #(
   parameter int NUMM    = 3,
   parameter int TIMEOUT = 255,
   localparam int IW     = (NUMM > 1) ? $clog2(NUMM) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NUMM-1:0] cyc,
   input  logic            bus_stb,
   input  logic            bus_ack,
   input  logic            bus_err,
   output logic [NUMM-1:0] grant,
   output logic            gnt_valid,
   output logic [IW-1:0]   gnt_idx,
   output logic            timeout_err
);

   typedef enum logic {IDLE, OWNED} state_t;

   state_t          state_q, state_d;
   logic [NUMM-1:0] grant_q, grant_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [IW-1:0]   lastPtr_q, lastPtr_d;
   logic            found;
   logic [IW-1:0]   pick;
   logic [IW-1:0]   cand;
   logic            ownerHeld;

   // Search starts just after the last winner; the dropping owner loses naturally since its cyc is 0.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int k = 1; k <= NUMM; k++) begin
         cand = IW'((int'(lastPtr_q) + k) % NUMM);
         if (!found && cyc[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      idx_d     = idx_q;
      lastPtr_d = lastPtr_q;
      ownerHeld = (state_q == OWNED) && cyc[idx_q];
      if (!ownerHeld) begin
         if (found) begin
            state_d   = OWNED;
            grant_d   = {{(NUMM-1){1'b0}}, 1'b1} << pick;
            idx_d     = pick;
            lastPtr_d = pick;
         end else begin
            state_d = IDLE;
            grant_d = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         idx_q     <= '0;
         lastPtr_q <= IW'(NUMM - 1);
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         idx_q     <= idx_d;
         lastPtr_q <= lastPtr_d;
      end
   end

   assign grant     = grant_q;
   assign gnt_valid = (state_q == OWNED);
   assign gnt_idx   = idx_q;

`ifdef WB_ARB_TIMEOUT_EN
   logic [7:0] wdCnt_q, wdCnt_d;
   logic       wdErr_q, wdErr_d;
   logic       stall;

   // A handover restarts the count so a new owner never inherits the previous owner's stall time.
   always_comb begin
      stall   = gnt_valid & bus_stb & ~bus_ack & ~bus_err;
      wdErr_d = 1'b0;
      wdCnt_d = wdCnt_q;
      if (stall && (wdCnt_q == 8'(TIMEOUT - 1))) begin
         wdErr_d = 1'b1;
         wdCnt_d = '0;
      end else if (!stall || (grant_d != grant_q)) begin
         wdCnt_d = '0;
      end else begin
         wdCnt_d = wdCnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdCnt_q <= '0;
         wdErr_q <= 1'b0;
      end else begin
         wdCnt_q <= wdCnt_d;
         wdErr_q <= wdErr_d;
      end
   end

   assign timeout_err = wdErr_q;
`else
   logic unusedBus;
   assign unusedBus   = ^{bus_stb, bus_ack, bus_err};
   assign timeout_err = 1'b0;
`endif

endmodule
